letc_core_rf: RTL and testbench

LETC_CORE_RF -- requirements
Module: letc_core_rf

---
 rtl/core_pkg.sv | 11 +
 rtl/letc_core_rf_rdport.sv | 45 ++++
 rtl/letc_core_rf.sv | 110 +++++++++++
 tb/tb_letc_core_rf.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared core types: register index, architectural register count, busy scoreboard vector.
// No logic; types and constants only.
// No flow control.
package core_pkg;

   localparam int NUM_ARCH_REGS = 32;

   typedef logic [4:0]  reg_idx_t;
   typedef logic [31:0] rf_busy_t;

endpackage : core_pkg

// File: rtl/letc_core_rf_rdport.sv
// One register-file read channel: selects stored data or same-cycle writeback forward, plus busy flag.
// Zero-cycle latency (purely combinational).
// No backpressure; output follows inputs every cycle.
//
// Ports:
//   i_idx       read index
//   i_regs      flattened register view, entry 0 is constant zero
//   i_busy      busy scoreboard, bit 0 always zero
//   i_wb_*      writeback in flight this cycle (used for forwarding)
//   i_en        low forces both outputs to zero (held in reset)
//   o_data      read data
//   o_busy      pending-write flag for the indexed register
module letc_core_rf_rdport
   import core_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int BYPASS = 1
) (
   input  logic [4:0]                                i_idx,
   input  logic [NUM_ARCH_REGS-1:0][XLEN-1:0]        i_regs,
   input  rf_busy_t                                  i_busy,
   input  logic                                      i_wb_valid,
   input  logic [4:0]                                i_wb_rd,
   input  logic [XLEN-1:0]                           i_wb_data,
   input  logic                                      i_en,
   output logic [XLEN-1:0]                           o_data,
   output logic                                      o_busy
);

   logic fwd;

   // Forwarding never applies to x0: a writeback aimed at x0 is discarded.
   assign fwd = (BYPASS != 0) && i_wb_valid && (i_wb_rd == i_idx) && (i_idx != 5'd0);

   always_comb begin
      o_data = '0;
      o_busy = 1'b0;
      if (i_en) begin
         o_data = fwd ? i_wb_data : i_regs[i_idx];
         // A forwarded value is final, so the register is no longer pending for this reader.
         o_busy = fwd ? 1'b0 : i_busy[i_idx];
      end
   end

endmodule : letc_core_rf_rdport

// File: rtl/letc_core_rf.sv
// Integer register file x0..x31 with multi-port combinational reads and a busy (pending-write) scoreboard.
// Reads zero-cycle latency; writes and busy updates land on the rising edge of i_clk.
// No backpressure; issue/writeback/flush are accepted unconditionally every cycle.
//
// Ports:
//   i_clk, i_rst_n               clock, asynchronous active-low reset
//   i_rs_idx / o_rs_data / o_rs_busy   per-channel read index, data and pending flag
//   i_issue_valid, i_issue_rd    marks rd busy at the edge
//   i_wb_valid, i_wb_rd, i_wb_data     writes data, clears busy at the edge
//   i_flush                      clears every busy bit at the edge
//   o_busy_any                   OR of all busy bits
module letc_core_rf
   import core_pkg::*;
#(
   parameter int XLEN         = 32,
   parameter int NUM_RD_PORTS = 2,
   parameter int BYPASS       = 1
) (
   input  logic                                  i_clk,
   input  logic                                  i_rst_n,
   input  reg_idx_t [NUM_RD_PORTS-1:0]           i_rs_idx,
   output logic [NUM_RD_PORTS-1:0][XLEN-1:0]     o_rs_data,
   output logic [NUM_RD_PORTS-1:0]               o_rs_busy,
   input  logic                                  i_issue_valid,
   input  reg_idx_t                              i_issue_rd,
   input  logic                                  i_wb_valid,
   input  reg_idx_t                              i_wb_rd,
   input  logic [XLEN-1:0]                       i_wb_data,
   input  logic                                  i_flush,
   output logic                                  o_busy_any
);

   // x0 has no storage; index 0 of the read view is tied to zero.
   logic [XLEN-1:0]                       regs_q [1:NUM_ARCH_REGS-1];
   logic [NUM_ARCH_REGS-1:0][XLEN-1:0]    rf_view;
   logic [NUM_ARCH_REGS-1:1]              busy_q;
   logic [NUM_ARCH_REGS-1:1]              busy_d;
   rf_busy_t                              busy_vec;

   // ------------------------------------------------------------------
   // Data storage
   // ------------------------------------------------------------------
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 1; i < NUM_ARCH_REGS; i++) begin
            regs_q[i] <= '0;
         end
      end else if (i_wb_valid && (i_wb_rd != 5'd0)) begin
         regs_q[i_wb_rd] <= i_wb_data;
      end
   end

   always_comb begin
      rf_view[0] = '0;
      for (int i = 1; i < NUM_ARCH_REGS; i++) begin
         rf_view[i] = regs_q[i];
      end
   end

   // ------------------------------------------------------------------
   // Busy scoreboard
   // Priority per bit: flush clears > issue sets > writeback clears.
   // Issue beating writeback on the same rd keeps the newer producer pending.
   // ------------------------------------------------------------------
   always_comb begin
      busy_d = busy_q;
      for (int i = 1; i < NUM_ARCH_REGS; i++) begin
         if (i_flush) begin
            busy_d[i] = 1'b0;
         end else if (i_issue_valid && (i_issue_rd == reg_idx_t'(i))) begin
            busy_d[i] = 1'b1;
         end else if (i_wb_valid && (i_wb_rd == reg_idx_t'(i))) begin
            busy_d[i] = 1'b0;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   assign busy_vec   = {busy_q, 1'b0};
   assign o_busy_any = |busy_q;

   // ------------------------------------------------------------------
   // Read channels
   // ------------------------------------------------------------------
   for (genvar n = 0; n < NUM_RD_PORTS; n++) begin : g_rdport
      letc_core_rf_rdport #(
         .XLEN   (XLEN),
         .BYPASS (BYPASS)
      ) u_rdport (
         .i_idx      (i_rs_idx[n]),
         .i_regs     (rf_view),
         .i_busy     (busy_vec),
         .i_wb_valid (i_wb_valid),
         .i_wb_rd    (i_wb_rd),
         .i_wb_data  (i_wb_data),
         // Storage is already zero in reset; this also blocks forwarding so outputs read zero.
         .i_en       (i_rst_n),
         .o_data     (o_rs_data[n]),
         .o_busy     (o_rs_busy[n])
      );
   end

endmodule : letc_core_rf

// File: tb/tb_letc_core_rf.sv
// Bench for letc_core_rf: one instance with forwarding, one without, sharing all inputs.
// Reads are combinational; expected values are queued at drive time and compared mid-cycle.
// No flow control in the design.
module tb_letc_core_rf;
   import core_pkg::*;

   localparam int NRD = 2;

   logic                     i_clk;
   logic                     i_rst_n;
   reg_idx_t [NRD-1:0]       rs_idx;
   logic                     issue_valid;
   reg_idx_t                 issue_rd;
   logic                     wb_valid;
   reg_idx_t                 wb_rd;
   logic [31:0]              wb_data;
   logic                     flush;

   logic [NRD-1:0][31:0]     data_byp, data_nb;
   logic [NRD-1:0]           busy_byp, busy_nb;
   logic                     any_byp, any_nb;

   letc_core_rf #(.XLEN(32), .NUM_RD_PORTS(NRD), .BYPASS(1)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_rs_idx(rs_idx),
      .o_rs_data(data_byp), .o_rs_busy(busy_byp),
      .i_issue_valid(issue_valid), .i_issue_rd(issue_rd),
      .i_wb_valid(wb_valid), .i_wb_rd(wb_rd), .i_wb_data(wb_data),
      .i_flush(flush), .o_busy_any(any_byp)
   );

   letc_core_rf #(.XLEN(32), .NUM_RD_PORTS(NRD), .BYPASS(0)) dut_nb (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_rs_idx(rs_idx),
      .o_rs_data(data_nb), .o_rs_busy(busy_nb),
      .i_issue_valid(issue_valid), .i_issue_rd(issue_rd),
      .i_wb_valid(wb_valid), .i_wb_rd(wb_rd), .i_wb_data(wb_data),
      .i_flush(flush), .o_busy_any(any_nb)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference state
   logic [31:0] m_regs [32];
   logic        m_busy [32];

   // Scoreboard
   string       tag_q [$];
   logic [31:0] exp_q [$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%08h exp=0x%08h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) begin
         m_regs[i] = '0;
         m_busy[i] = 1'b0;
      end
   endtask

   task automatic model_update();
      if (wb_valid && wb_rd != 5'd0) m_regs[wb_rd] = wb_data;
      if (flush) begin
         for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
      end else begin
         if (wb_valid) m_busy[wb_rd] = 1'b0;
         if (issue_valid && issue_rd != 5'd0) m_busy[issue_rd] = 1'b1;
      end
   endtask

   task automatic push(input string tag, input logic [31:0] v);
      tag_q.push_back(tag);
      exp_q.push_back(v);
   endtask

   task automatic expect_push();
      logic any;
      any = 1'b0;
      for (int i = 0; i < 32; i++) any = any | m_busy[i];
      for (int ch = 0; ch < NRD; ch++) begin
         reg_idx_t idx;
         logic     fwd;
         idx = rs_idx[ch];
         fwd = wb_valid && (wb_rd == idx) && (idx != 5'd0);
         if (!i_rst_n) begin
            push($sformatf("ch%0d_byp_data", ch), 32'd0);
            push($sformatf("ch%0d_byp_busy", ch), 32'd0);
            push($sformatf("ch%0d_nb_data", ch), 32'd0);
            push($sformatf("ch%0d_nb_busy", ch), 32'd0);
         end else begin
            push($sformatf("ch%0d_byp_data", ch), fwd ? wb_data : m_regs[idx]);
            push($sformatf("ch%0d_byp_busy", ch), {31'd0, fwd ? 1'b0 : m_busy[idx]});
            push($sformatf("ch%0d_nb_data", ch), m_regs[idx]);
            push($sformatf("ch%0d_nb_busy", ch), {31'd0, m_busy[idx]});
         end
      end
      push("byp_busy_any", {31'd0, any & i_rst_n});
      push("nb_busy_any",  {31'd0, any & i_rst_n});
   endtask

   task automatic pop_chk(input logic [31:0] got);
      string       tag;
      logic [31:0] exp;
      tag = tag_q.pop_front();
      exp = exp_q.pop_front();
      chk(tag, got, exp);
   endtask

   task automatic compare_pop();
      for (int ch = 0; ch < NRD; ch++) begin
         pop_chk(data_byp[ch]);
         pop_chk({31'd0, busy_byp[ch]});
         pop_chk(data_nb[ch]);
         pop_chk({31'd0, busy_nb[ch]});
      end
      pop_chk({31'd0, any_byp});
      pop_chk({31'd0, any_nb});
   endtask

   task automatic idle();
      issue_valid = 1'b0;
      issue_rd    = '0;
      wb_valid    = 1'b0;
      wb_rd       = '0;
      wb_data     = '0;
      flush       = 1'b0;
   endtask

   task automatic set_rs(input reg_idx_t a, input reg_idx_t b);
      rs_idx[0] = a;
      rs_idx[1] = b;
   endtask

   task automatic wb(input reg_idx_t rd, input logic [31:0] d);
      wb_valid = 1'b1;
      wb_rd    = rd;
      wb_data  = d;
   endtask

   task automatic issue(input reg_idx_t rd);
      issue_valid = 1'b1;
      issue_rd    = rd;
   endtask

   // One cycle: queue expectations for current inputs, compare mid-cycle, advance model at the edge.
   task automatic cycle();
      expect_push();
      @(negedge i_clk);
      compare_pop();
      @(posedge i_clk);
      if (i_rst_n) model_update();
      #1;
      idle();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      i_rst_n = 1'b0;
      idle();
      set_rs(5'd0, 5'd0);
      #2;
      expect_push(); compare_pop();
      set_rs(5'd5, 5'd31);
      wb(5'd5, 32'hCAFE_F00D);
      #1;
      expect_push(); compare_pop();
      @(posedge i_clk); #1;
      i_rst_n = 1'b1;
      idle();

      // Write x5, observe forward vs stored path, then read back on all channels
      set_rs(5'd5, 5'd5); wb(5'd5, 32'hDEAD_BEEF); cycle();
      set_rs(5'd5, 5'd5); cycle();

      // x0 write discarded, x0 issue ignored
      set_rs(5'd0, 5'd0); wb(5'd0, 32'h1234_5678); issue(5'd0); cycle();
      set_rs(5'd0, 5'd5); cycle();

      // x7 pending, then write while reading
      set_rs(5'd7, 5'd7); issue(5'd7); cycle();
      set_rs(5'd7, 5'd7); wb(5'd7, 32'hA5A5_A5A5); cycle();
      set_rs(5'd7, 5'd5); cycle();

      // Issue beats writeback on same rd
      set_rs(5'd3, 5'd0); issue(5'd3); cycle();
      set_rs(5'd3, 5'd3); issue(5'd3); wb(5'd3, 32'h0000_0033); cycle();
      set_rs(5'd3, 5'd7); wb(5'd3, 32'h0000_0034); cycle();
      set_rs(5'd3, 5'd3); cycle();

      // Flush outranks issue
      issue(5'd1);  set_rs(5'd1, 5'd2); cycle();
      issue(5'd2);  set_rs(5'd1, 5'd2); cycle();
      issue(5'd31); set_rs(5'd31, 5'd2); cycle();
      flush = 1'b1; issue(5'd4); wb(5'd6, 32'h0000_0066); set_rs(5'd31, 5'd4); cycle();
      set_rs(5'd4, 5'd6); cycle();

      // Issue and writeback to different rds, plus writeback to a non-busy register
      issue(5'd10); wb(5'd11, 32'h0BAD_F00D); set_rs(5'd10, 5'd11); cycle();
      set_rs(5'd10, 5'd11); cycle();

      // Asynchronous reset mid-cycle with a writeback in flight
      set_rs(5'd9, 5'd9); wb(5'd9, 32'h0000_0055); cycle();
      set_rs(5'd9, 5'd12); wb(5'd9, 32'h0000_0077); issue(5'd12);
      expect_push();
      @(negedge i_clk);
      compare_pop();
      #2;
      i_rst_n = 1'b0;
      model_reset();
      #1;
      expect_push(); compare_pop();
      @(posedge i_clk); #1;
      expect_push(); compare_pop();
      i_rst_n = 1'b1;
      idle();
      set_rs(5'd9, 5'd12); cycle();

      // Random traffic
      for (int k = 0; k < 60; k++) begin
         issue_valid = 1'($urandom_range(0, 1));
         issue_rd    = reg_idx_t'($urandom_range(0, 31));
         wb_valid    = 1'($urandom_range(0, 1));
         wb_rd       = reg_idx_t'($urandom_range(0, 31));
         wb_data     = $urandom();
         flush       = ($urandom_range(0, 9) == 0);
         if ((k % 3) == 0) set_rs(wb_rd, issue_rd);
         else set_rs(reg_idx_t'($urandom_range(0, 31)), reg_idx_t'($urandom_range(0, 31)));
         cycle();
      end

      chk("sb_drain", tag_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule : tb_letc_core_rf
